// File: rtl/hidden_cpu_feeder_pkg.sv
// hidden_cpu_feeder_pkg: shared FSM/phase types, pin-bus bit positions and opcode codes
package hidden_cpu_feeder_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RST_CPU, S_RUN, S_DRAIN, S_DONE} state_e;
   typedef enum logic {PH_A = 1'b0, PH_B = 1'b1} phase_e;
   localparam int CLK_BIT = 0;
   localparam int RST_BIT = 1;
   localparam int INSTR_LSB = 2;
   localparam int INSTR_W = 6;
   localparam logic [1:0] OPC_0 = 2'd0;
   localparam logic [1:0] OPC_1 = 2'd1;
   localparam logic [1:0] OPC_2 = 2'd2;
   localparam logic [1:0] OPC_3 = 2'd3;
endpackage

// File: rtl/hidden_cpu_feeder_prog_mem.sv
// feeder_prog_mem: program store, synchronous write and asynchronous read
module feeder_prog_mem
   import hidden_cpu_feeder_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int ADDR_W = 4
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [INSTR_W-1:0] rdata
);
   logic [INSTR_W-1:0] mem [DEPTH];
   always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/hidden_cpu_feeder.sv
// hidden_cpu_feeder: loads a program, clocks/resets the hidden CPU over its pin bus and streams results back.
// Define PC_TRACK_EN to fetch from the CPU's reported pc instead of a sequential pointer.
module hidden_cpu_feeder
   import hidden_cpu_feeder_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int ADDR_W = 4,
   parameter int RST_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [5:0] load_data,
   input  logic       load_last,
   input  logic       start,
   input  logic       stop,
   output logic       busy,
   output logic       done,
   output logic [7:0] cpu_io_in,
   input  logic [7:0] cpu_io_out,
   output logic [7:0] result,
   output logic       result_valid
);
   localparam int CNT_W = ADDR_W + 2;
   state_e state_q, state_d;
   phase_e ph_q, ph_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d, addr_q, addr_d, waddr, raddr;
   logic [ADDR_W:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [INSTR_W-1:0] instr_q, instr_d, rdata, pin_instr;
   logic [7:0] result_q, result_d;
   logic result_valid_q, result_valid_d, first_q, first_d, stop_q, stop_d;
   logic idle_like, beat, we, last_step;

   feeder_prog_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
      .clk(clk), .we(we), .waddr(waddr), .wdata(load_data), .raddr(raddr), .rdata(rdata)
   );

   assign idle_like = state_q == S_IDLE || state_q == S_DONE;
   assign load_ready = idle_like || state_q == S_LOAD;
   assign beat = load_valid && load_ready;
   assign waddr = idle_like ? '0 : wptr_q;
   assign busy = state_q == S_RST_CPU || state_q == S_RUN || state_q == S_DRAIN;
   assign done = state_q == S_DONE;
   assign result = result_q;
   assign result_valid = result_valid_q;
`ifdef PC_TRACK_EN
   assign raddr = cpu_io_out[ADDR_W-1:0];
   assign last_step = {1'b0, addr_q} + 1'b1 >= len_q || cnt_q == CNT_W'(4*DEPTH-1);
`else
   assign raddr = cnt_q[ADDR_W-1:0];
   assign last_step = {1'b0, addr_q} + 1'b1 >= len_q;
`endif
   // instruction is live from memory in phase A and held through phase B
   assign pin_instr = state_q != S_RUN ? '0 : ph_q == PH_A ? rdata : instr_q;
   assign cpu_io_in[7:INSTR_LSB] = pin_instr;
   assign cpu_io_in[RST_BIT] = state_q == S_RST_CPU;
   assign cpu_io_in[CLK_BIT] = (state_q == S_RST_CPU || state_q == S_RUN) && ph_q == PH_B;

   always_comb begin
      state_d = state_q;
      ph_d = PH_A;
      wptr_d = wptr_q;
      len_d = len_q;
      cnt_d = cnt_q;
      addr_d = addr_q;
      instr_d = instr_q;
      result_d = result_q;
      result_valid_d = 1'b0;
      first_d = first_q;
      stop_d = stop_q;
      we = 1'b0;
      if (beat) begin
         we = 1'b1;
         wptr_d = waddr + 1'b1;
         state_d = S_LOAD;
         if (load_last || waddr == ADDR_W'(DEPTH-1)) begin
            state_d = S_IDLE;
            len_d = {1'b0, waddr} + 1'b1;
         end
      end else if (start && idle_like) begin
         state_d = len_q == '0 ? S_DONE : S_RST_CPU;
         cnt_d = '0;
      end
      case (state_q)
         S_RST_CPU: begin
            ph_d = ph_q == PH_A ? PH_B : PH_A;
            cnt_d = ph_q == PH_B ? cnt_q + 1'b1 : cnt_q;
            if (ph_q == PH_B && cnt_q == CNT_W'(RST_CYCLES-1)) begin
               state_d = S_RUN;
               cnt_d = '0;
               first_d = 1'b1;
               stop_d = 1'b0;
            end
         end
         S_RUN: begin
            ph_d = ph_q == PH_A ? PH_B : PH_A;
            if (ph_q == PH_A) begin
               addr_d = raddr;
               instr_d = rdata;
               first_d = 1'b0;
               stop_d = stop;
               result_d = first_q ? result_q : cpu_io_out;
               result_valid_d = !first_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
               state_d = stop || stop_q || last_step ? S_DRAIN : S_RUN;
            end
         end
         S_DRAIN: begin
            result_d = cpu_io_out;
            result_valid_d = 1'b1;
            state_d = S_DONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ph_q <= PH_A;
         wptr_q <= '0;
         len_q <= '0;
         cnt_q <= '0;
         addr_q <= '0;
         instr_q <= '0;
         result_q <= '0;
         result_valid_q <= 1'b0;
         first_q <= 1'b0;
         stop_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q <= ph_d;
         wptr_q <= wptr_d;
         len_q <= len_d;
         cnt_q <= cnt_d;
         addr_q <= addr_d;
         instr_q <= instr_d;
         result_q <= result_d;
         result_valid_q <= result_valid_d;
         first_q <= first_d;
         stop_q <= stop_d;
      end
   end
endmodule

// File: tb/tb_hidden_cpu_feeder.sv
// tb_hidden_cpu_feeder: directed tests with a behavioural CPU model and per-cycle pin protocol checks.
module tb_hidden_cpu_feeder;
`ifdef PC_TRACK_EN
   localparam bit PCT = 1'b1;
`else
   localparam bit PCT = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic load_valid = 1'b0, load_last = 1'b0, start = 1'b0, stop = 1'b0;
   logic [5:0] load_data = '0;
   logic load_ready, busy, done, result_valid;
   logic [7:0] cpu_io_in, cpu_io_out, result;
   int n_vec = 0, n_err = 0;
   logic pc_mode = 1'b0, jump_en = 1'b0;
   logic [5:0] cpu_pc = '0, cpu_last = '0;
   logic [5:0] exec_q[$], exp_exec[$];
   logic [7:0] res_q[$], exp_res[$], pin_q[$];
   logic [7:0] prev_pins = '0;
   logic prev_busy = 1'b0;
   logic [5:0] prog [16];

   always #5 clk = ~clk;

   hidden_cpu_feeder dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .load_last(load_last), .start(start), .stop(stop), .busy(busy), .done(done),
      .cpu_io_in(cpu_io_in), .cpu_io_out(cpu_io_out), .result(result), .result_valid(result_valid)
   );

   // model CPU: executes one instruction per rising edge of its pin clock
   assign cpu_io_out = pc_mode ? {2'b00, cpu_pc} : {2'b10, cpu_last};
   always @(posedge cpu_io_in[0]) begin
      if (cpu_io_in[1]) begin
         cpu_pc <= '0;
         cpu_last <= '0;
      end else begin
         cpu_last <= cpu_io_in[7:2];
         cpu_pc <= (jump_en && cpu_pc == 6'd1) ? 6'd5 : cpu_pc + 6'd1;
         exec_q.push_back(cpu_io_in[7:2]);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("ready_vs_busy", 32'(load_ready), 32'(!busy));
         check("busy_done_excl", 32'(busy && done), 32'd0);
         if (!busy) check("idle_pins", 32'(cpu_io_in), 32'd0);
         if (cpu_io_in[0]) check("phase_b_hold", 32'(cpu_io_in), 32'(prev_pins | 8'h01));
         if (prev_busy && !prev_pins[0] && busy) check("phase_alternate", 32'(cpu_io_in[0]), 32'd1);
         if (result_valid) begin
            check("valid_after_busy", 32'(prev_busy), 32'd1);
            res_q.push_back(result);
         end
         pin_q.push_back(cpu_io_in);
      end
      prev_pins = cpu_io_in;
      prev_busy = busy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_prog(input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         check("load_ready_beat", 32'(load_ready), 32'd1);
         load_valid = 1'b1;
         load_data = prog[i];
         load_last = with_last && i == n - 1;
         tick();
      end
      load_valid = 1'b0;
      load_last = 1'b0;
   endtask

   task automatic run(input string name, input int stop_step);
      int cyc;
      exec_q.delete();
      res_q.delete();
      pin_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 500) begin
         if (stop_step > 0 && busy && cpu_io_in[1:0] == 2'b00 && exec_q.size() == stop_step - 1) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
         end else tick();
         cyc++;
      end
      check({name, " done"}, 32'(done), 32'd1);
      tick();
   endtask

   task automatic model_seq(input int n, input bit pcm);
      exp_exec.delete();
      exp_res.delete();
      for (int i = 0; i < n; i++) begin
         exp_exec.push_back(prog[i]);
         exp_res.push_back(pcm ? 8'(i + 1) : {2'b10, prog[i]});
      end
   endtask

   task automatic compare_run(input string name);
      check({name, " steps"}, 32'(exec_q.size()), 32'(exp_exec.size()));
      check({name, " pulses"}, 32'(res_q.size()), 32'(exp_res.size()));
      foreach (exp_exec[i])
         if (i < exec_q.size()) check($sformatf("%s instr%0d", name, i), 32'(exec_q[i]), 32'(exp_exec[i]));
      foreach (exp_res[i])
         if (i < res_q.size()) check($sformatf("%s result%0d", name, i), 32'(res_q[i]), 32'(exp_res[i]));
   endtask

   initial begin
      logic [7:0] t1_pins [11];
      logic [7:0] t1_res [3];
      int cyc, a, nxt;
      t1_pins = '{8'h02, 8'h03, 8'h02, 8'h03, 8'h04, 8'h05, 8'h48, 8'h49, 8'hFC, 8'hFD, 8'h00};
      t1_res[0] = PCT ? 8'h01 : 8'h81;
      t1_res[1] = PCT ? 8'h02 : 8'h92;
      t1_res[2] = PCT ? 8'h03 : 8'hBF;
      pc_mode = PCT;
      tick();
      tick();
      rst = 1'b0;
      check("rst load_ready", 32'(load_ready), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst result", 32'(result), 32'd0);
      check("rst result_valid", 32'(result_valid), 32'd0);
      check("rst pins", 32'(cpu_io_in), 32'd0);

      // empty program: start goes straight to DONE
      res_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t3 done", 32'(done), 32'd1);
      check("t3 pins", 32'(cpu_io_in), 32'd0);
      tick();
      tick();
      check("t3 no results", 32'(res_q.size()), 32'd0);

      prog[0] = 6'h01;
      prog[1] = 6'h12;
      prog[2] = 6'h3F;
      load_prog(3, 1'b1);
      check("t1 done cleared", 32'(done), 32'd0);
      run("t1", 0);
      for (int i = 0; i < 11; i++)
         if (i + 1 < pin_q.size()) check($sformatf("t1 pins%0d", i), 32'(pin_q[i + 1]), 32'(t1_pins[i]));
      check("t1 pulses lit", 32'(res_q.size()), 32'd3);
      for (int i = 0; i < 3; i++) if (i < res_q.size()) check($sformatf("t1 res_lit%0d", i), 32'(res_q[i]), 32'(t1_res[i]));
      model_seq(3, PCT);
      compare_run("t1");

      for (int i = 0; i < 16; i++) prog[i] = 6'(i * 7 + 3);
      load_prog(16, 1'b0);
      check("t2 ready after forced end", 32'(load_ready), 32'd1);
      check("t2 busy", 32'(busy), 32'd0);
      run("t2", 0);
      check("t2 pulses lit", 32'(res_q.size()), 32'd16);
      model_seq(16, PCT);
      compare_run("t2");

      for (int i = 0; i < 10; i++) prog[i] = 6'(i * 11 + 1);
      load_prog(10, 1'b1);
      run("t4", 2);
      check("t4 pulses lit", 32'(res_q.size()), 32'd2);
      model_seq(2, PCT);
      compare_run("t4");

      // reset in the middle of a run drops the program length
      pc_mode = 1'b1;
      for (int i = 0; i < 5; i++) prog[i] = 6'(i + 40);
      load_prog(5, 1'b1);
      exec_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (exec_q.size() < 2 && cyc < 100) begin
         tick();
         cyc++;
      end
      check("t5 reached run", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      check("t5 busy", 32'(busy), 32'd0);
      check("t5 pins", 32'(cpu_io_in), 32'd0);
      check("t5 load_ready", 32'(load_ready), 32'd1);
      check("t5 result", 32'(result), 32'd0);
      rst = 1'b0;
      res_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t5 restart done", 32'(done), 32'd1);
      tick();
      tick();
      check("t5 no results", 32'(res_q.size()), 32'd0);

`ifdef PC_TRACK_EN
      jump_en = 1'b1;
      for (int i = 0; i < 7; i++) prog[i] = 6'(i * 9 + 2);
      load_prog(7, 1'b1);
      run("t6", 0);
      check("t6 steps lit", 32'(exec_q.size()), 32'd4);
      if (exec_q.size() > 2) check("t6 jump lit", 32'(exec_q[2]), 32'(prog[5]));
      exp_exec.delete();
      exp_res.delete();
      a = 0;
      for (int k = 0; k < 64; k++) begin
         exp_exec.push_back(prog[a]);
         nxt = a == 1 ? 5 : a + 1;
         exp_res.push_back(8'(nxt));
         if (a >= 6) break;
         a = nxt;
      end
      compare_run("t6");
      jump_en = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end
endmodule

// File: doc/hidden_cpu_feeder.md
Name: hidden_cpu_feeder

Overview:
Host-side driver for the 8-bit hidden CPU pin interface. It holds a small program of 6-bit instruction words loaded through a valid/ready port. It generates the CPU's clock and reset on the pin bus and presents one instruction per CPU clock. It samples the CPU's 8-bit output after every step and streams it back to the host. It is the initiator end of the CPU's io_in/io_out protocol.

Parameters:
DEPTH, 16, program memory entries (power of two, 2..64)
ADDR_W, 4, log2(DEPTH)
RST_CYCLES, 2, CPU clock periods during which the CPU reset pin is held high before the first instruction

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
load_valid  input  1  host instruction word valid
load_ready  output  1  feeder accepts a load beat
load_data  input  6  instruction word: [5:4] opcode, [3:0] register address fields
load_last  input  1  final word of the program
start  input  1  one-cycle pulse; begin a run (honoured in IDLE/DONE only)
stop  input  1  one-cycle pulse; end the run early
busy  output  1  high in RST_CPU/RUN/DRAIN
done  output  1  high in DONE
cpu_io_in  output  8  CPU pin bus: [0] CPU clock, [1] CPU reset, [7:2] instruction
cpu_io_out  input  8  CPU output pins (r3 or pc)
result  output  8  last sampled cpu_io_out
result_valid  output  1  one-cycle pulse per sample

Behaviour:
- Reset: FSM=IDLE; load_ready=1; busy=0; done=0; result=0; result_valid=0; cpu_io_in=8'h00; length=0; write pointer=0. Memory contents are not cleared.
- States: IDLE, LOAD, RST_CPU, RUN, DRAIN, DONE. Each CPU clock period is 2 sys cycles:
  - phase A: cpu_io_in[0]=0, instruction driven.
  - phase B: cpu_io_in[0]=1; the CPU's rising edge occurs here.
  - cpu_io_in[7:2] changes only at the start of phase A.
- Load:
  - A beat is accepted when load_valid&load_ready; it writes mem[wptr] and increments wptr.
  - The first beat from IDLE/DONE resets wptr to 0 first and moves the FSM to LOAD.
  - Load ends on load_last, or forcibly on the beat at wptr==DEPTH-1. At that point length=wptr+1 and the FSM enters IDLE.
  - load_ready=0 in RST_CPU/RUN/DRAIN.
- start in IDLE/DONE:
  - If length==0, go to DONE next cycle with no CPU activity.
  - Otherwise enter RST_CPU and clear done. cpu_io_in[1]=1 and instruction=0 for RST_CYCLES periods (2*RST_CYCLES sys cycles).
- RUN:
  - Fetch pointer fp starts at 0. Phase A drives mem[fp]; phase B increments fp.
  - In every phase A except the first after RST_CPU, register cpu_io_out into result and pulse result_valid.
  - After the phase B of the step with fp==length-1, go to DRAIN. DRAIN is one phase A: sample and pulse result_valid, then go to DONE.
  - Exactly length result pulses per run.
- stop during RUN: the current period completes (its phase B still occurs), then DRAIN. stop is ignored in IDLE/LOAD/RST_CPU/DONE. start during busy is ignored.
- DONE: cpu_io_in[0]=0, instruction=0, reset pin low; done held until the next start or load beat.
- rst mid-run: FSM returns to IDLE in the same cycle. cpu_io_in goes to 00. length=0, so a program reload is required.

Optional Feature:
PC_TRACK_EN:
- Defined: in RUN, phase A fetches mem[cpu_io_out[ADDR_W-1:0]] instead of mem[fp]. This follows CPU branches; the host must keep the CPU output mux on pc. The run ends after the step whose fetched address is >= length-1, or on stop. A safety limit of 4*DEPTH steps also forces DRAIN. Result pulses equal the number of executed steps.
- Undefined: fetch is sequential via fp as above, and cpu_io_out affects only result.

Decomposition:
- Shared package: state enum, phase encoding, cpu_io_in bit-position constants (CLK_BIT=0, RST_BIT=1, INSTR_LSB=2), and opcode constants.
- One natural sub-module, feeder_prog_mem: DEPTH x 6 synchronous-write, asynchronous-read array with write port (we, waddr, wdata) and read port (raddr, rdata).

Test Plan:
1. Reset, then load 3 words (0x01, 0x12, 0x3F, last on the third) and start. Required: 2*RST_CYCLES cycles with cpu_io_in[1]=1. Then cpu_io_in[7:2] presents 0x01, 0x12, 0x3F each for 2 cycles, with bit0 toggling 0,1. Exactly 3 result_valid pulses follow, then done=1.
2. Load 16 words without load_last. Required: forced end at the 16th beat; load_ready stays high in IDLE; length=16. A run gives 16 result pulses.
3. Start with length 0 (fresh reset). Required: done=1 on the next cycle; cpu_io_in stays 00; no result_valid.
4. Stop asserted during phase A of step 2 of a 10-word program. Required: step 2's phase B occurs, then DRAIN. Exactly 2 result pulses, then done.
5. Model CPU returns pc. Assert rst during RUN. Required: next cycle busy=0, cpu_io_in=00, load_ready=1. A start without reload goes straight to DONE.
6. With PC_TRACK_EN, the model CPU jumps from pc 1 to pc 5 on a 7-word program. Required: fetched sequence mem[0], mem[1], mem[5], mem[6]; run ends after address 6 with 4 result pulses.
